// File: rtl/ascon_share_slicer.sv
// ascon_share_slicer: streams a masked Ascon state out LSB-first as PAR-bit column slices,
// one beat per cycle, keeping every share lane independent.
module ascon_share_slicer #(
  parameter int PAR        = 6,
  parameter int COL_SIZE   = 5,
  parameter int WORD_SIZE  = 64,
  parameter int NUM_SHARES = 11,
  localparam int NUM_BEATS = (WORD_SIZE + PAR - 1) / PAR,
  localparam int NBW       = $clog2(PAR + 1),
  localparam int IW        = $clog2(NUM_BEATS)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_SHARES*COL_SIZE*WORD_SIZE-1:0] in_state,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_SHARES*COL_SIZE*PAR-1:0]       out_slice,
  output logic [NBW-1:0]                           out_nbits,
  output logic [IW-1:0]                            out_idx,
  output logic                                     out_last
);
  localparam int LANES     = NUM_SHARES * COL_SIZE;
  localparam int LAST_BITS = (WORD_SIZE % PAR == 0) ? PAR : WORD_SIZE % PAR;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BEATS - 1);
  typedef enum logic {IDLE, STREAM} state_e;
  state_e                       state_q, state_d;
  logic [LANES*WORD_SIZE-1:0]   sr_q, sr_d, sr_sh;
  logic [LANES*PAR-1:0]         slice;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         stream, is_last, accept, load;
  // Each lane shifts on its own, so no bit ever crosses into a neighbouring share or row.
  always_comb begin
    sr_sh = '0;
    slice = '0;
    for (int l = 0; l < LANES; l++) begin
      sr_sh[l*WORD_SIZE +: WORD_SIZE] = sr_q[l*WORD_SIZE +: WORD_SIZE] >> PAR;
      slice[l*PAR +: PAR]             = sr_q[l*WORD_SIZE +: PAR];
    end
  end
  always_comb begin
    stream   = state_q == STREAM;
    is_last  = stream && idx_q == LAST_IDX;
    accept   = stream && out_ready;
    in_ready = !stream || (accept && is_last);
    load     = in_valid && in_ready;
    state_d  = clear ? IDLE : load ? STREAM : (accept && is_last) ? IDLE : state_q;
    sr_d     = clear ? '0 : load ? in_state : accept ? sr_sh : sr_q;
    idx_d    = (clear || load || (accept && is_last)) ? '0 : accept ? idx_q + IW'(1) : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end
  assign out_valid = stream;
  assign out_slice = stream ? slice : '0;
  assign out_idx   = idx_q;
  assign out_last  = is_last;
  assign out_nbits = !stream ? '0 : is_last ? NBW'(LAST_BITS) : NBW'(PAR);
endmodule

// File: tb/tb_ascon_share_slicer.sv
// tb_ascon_share_slicer: table vectors, directed corner sequences and a randomized
// stream compared against a word-shift reference model.
module tb_ascon_share_slicer;
  localparam int PAR = 6, COLS = 5, WS = 64, NSH = 11;
  localparam int LANES = NSH * COLS, ST_W = LANES * WS, SL_W = LANES * PAR, NB = 11;
  logic            clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [ST_W-1:0] in_state = '0;
  logic            in_ready, out_valid, out_last;
  logic [SL_W-1:0] out_slice;
  logic [2:0]      out_nbits;
  logic [3:0]      out_idx;
  int              errors = 0, checks = 0;

  ascon_share_slicer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
    .out_nbits(out_nbits), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    logic        all_lanes;
    int          beat;
    logic [5:0]  lane;
    logic [2:0]  nbits;
    logic        last;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: beat b of a lane is simply the word shifted down by b*PAR, truncated to PAR bits.
  function automatic logic [SL_W-1:0] model(input logic [ST_W-1:0] st, input int b);
    logic [SL_W-1:0] m;
    logic [63:0] w;
    m = '0;
    for (int l = 0; l < LANES; l++) begin
      w = st[l*WS +: WS] >> (b * PAR);
      m[l*PAR +: PAR] = w[5:0];
    end
    return m;
  endfunction

  function automatic logic [ST_W-1:0] rnd_state();
    logic [ST_W-1:0] r;
    for (int i = 0; i < ST_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ST_W-1:0] mk_state(input logic [63:0] w, input logic all);
    logic [ST_W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) if (all || l == 0) r[l*WS +: WS] = w;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ST_W-1:0] st);
    in_valid = 1; in_state = st; out_ready = 0;
    step();
    in_valid = 0;
  endtask

  task automatic advance(input int n);
    out_ready = 1;
    repeat (n) step();
    out_ready = 0;
  endtask

  task automatic do_clear();
    clear = 1; in_valid = 0; out_ready = 0;
    step();
    clear = 0;
  endtask

  logic [ST_W-1:0] sa, sb, cur, nxt;
  logic [SL_W-1:0] held;
  int              b;
  logic            active, acc, lastacc, ld;

  initial begin
    tbl[0] = '{64'hFEDCBA9876543210, 1'b0, 0,  6'h10, 3'd6, 1'b0};
    tbl[1] = '{64'hFEDCBA9876543210, 1'b0, 1,  6'h08, 3'd6, 1'b0};
    tbl[2] = '{64'hFEDCBA9876543210, 1'b0, 10, 6'h0F, 3'd4, 1'b1};
    tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 0,  6'h3F, 3'd6, 1'b0};
    tbl[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 9,  6'h3F, 3'd6, 1'b0};
    tbl[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 10, 6'h0F, 3'd4, 1'b1};

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_slice", out_slice, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_nbits", out_nbits, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1;
    step();

    foreach (tbl[i]) begin
      sa = mk_state(tbl[i].word, tbl[i].all_lanes);
      load(sa);
      advance(tbl[i].beat);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_lane00", i), out_slice[5:0], tbl[i].lane);
      chk($sformatf("tbl%0d_idx", i), out_idx, tbl[i].beat);
      chk($sformatf("tbl%0d_nbits", i), out_nbits, tbl[i].nbits);
      chk($sformatf("tbl%0d_last", i), out_last, tbl[i].last);
      chk($sformatf("tbl%0d_slice", i), out_slice, model(sa, tbl[i].beat));
      if (tbl[i].beat == 10) begin
        advance(1);
        chk($sformatf("tbl%0d_idle", i), out_valid, 0);
        chk($sformatf("tbl%0d_ready", i), in_ready, 1);
      end else do_clear();
    end

    // Backpressure at idx 2
    sa = rnd_state();
    load(sa);
    advance(2);
    held = out_slice;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_idx", out_idx, 2);
      chk("bp_slice", out_slice, held);
      chk("bp_slice_mdl", out_slice, model(sa, 2));
    end
    advance(1);
    chk("bp_resume", out_idx, 3);
    chk("bp_resume_slice", out_slice, model(sa, 3));
    do_clear();

    // Back-to-back: B is taken on A's beat-10 accept, giving 22 consecutive beats
    sa = rnd_state();
    sb = rnd_state();
    load(sa);
    out_ready = 1;
    for (int t = 0; t < 22; t++) begin
      in_valid = t <= 10;
      in_state = sb;
      #1;
      chk($sformatf("b2b_valid%0d", t), out_valid, 1);
      chk($sformatf("b2b_idx%0d", t), out_idx, t % NB);
      chk($sformatf("b2b_slice%0d", t), out_slice, model(t < NB ? sa : sb, t % NB));
      if (t == 10) chk("b2b_ready10", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 0; out_ready = 0;
    #1;
    chk("b2b_end", out_valid, 0);
    step();

    // clear at idx 5 wins over a pending load
    sa = rnd_state();
    load(sa);
    advance(5);
    chk("clr_idx5", out_idx, 5);
    clear = 1; in_valid = 1; in_state = rnd_state(); out_ready = 1;
    step();
    clear = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("clr_valid", out_valid, 0);
    chk("clr_ready", in_ready, 1);
    chk("clr_idx", out_idx, 0);
    chk("clr_slice", out_slice, 0);
    step();
    chk("clr_noload", out_valid, 0);

    // Asynchronous reset mid-stream
    sa = rnd_state();
    load(sa);
    advance(4);
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_slice", out_slice, 0);
    chk("arst_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("arst_stays_idle", out_valid, 0);

    // Randomized stream: random backpressure and random arrivals against the model
    active = 0; b = 0; cur = '0; nxt = rnd_state();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      in_state  = nxt;
      #1;
      acc = active && out_ready;
      lastacc = acc && b == NB - 1;
      ld = in_valid && (!active || lastacc);
      chk("rnd_valid", out_valid, active);
      chk("rnd_ready", in_ready, !active || lastacc);
      if (active) begin
        chk("rnd_slice", out_slice, model(cur, b));
        chk("rnd_idx", out_idx, b);
        chk("rnd_nbits", out_nbits, b == NB - 1 ? 4 : 6);
        chk("rnd_last", out_last, b == NB - 1);
      end
      if (ld) begin
        cur = nxt; b = 0; active = 1; nxt = rnd_state();
      end else if (lastacc) active = 0;
      else if (acc) b++;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
